riscv_fetch_stage: RTL and testbench

IF stage of the five-stage RISC-V pipeline: holds the PC, reads instruction memory, and loads the IF/ID instruction register feeding decode/register fetch. It accepts a stall from the load-use hazard logic and a redirect from branch resolution, injecting NOPs (32'h0000_0013) on flush. It also detects end-of-program, a zero instruction word or an out-of-range fetch. On that event it stops fetching, drains the downstream stages with NOPs, then raises `halted` for the bench.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_fetch_stage.sv | 119 +++++++++++
 tb/tb_riscv_fetch_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the five-stage RISC-V pipeline: opcodes, the canonical
// NOP word and the fetch-stage state encoding.
package riscv_pkg;

   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] BEQ    = 7'b1100011;
   localparam logic [6:0] R_type = 7'b0110011;
   localparam logic [6:0] I_type = 7'b0010011;

   // addi x0, x0, 0 -- the bubble injected on flush and during drain
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_stage.sv
// IF stage: PC register, instruction fetch into the IF/ID register, and the
// end-of-program drain sequence that ends in a sticky halted flag.
module riscv_fetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH   = 1024,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid,
   output logic [31:0] pc,
   output logic        halted
);

   localparam int unsigned CNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ifidIr_q, ifidIr_d;
   logic [31:0]      ifidPc_q, ifidPc_d;
   logic             ifidValid_q, ifidValid_d;
   logic [CNT_W-1:0] drainCnt_q, drainCnt_d;

   logic [31:0] redirectTarget;
   logic        endOfProgram;
   logic        unusedRedirectBits;

   assign redirectTarget     = {redirect_pc[31:2], 2'b00};
   assign unusedRedirectBits = ^redirect_pc[1:0];
   // A zero word or a fetch past the end of instruction memory both mean the program is over
   assign endOfProgram       = (imem_rdata == 32'h0) || (pc_q[31:2] >= DEPTH_WORDS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         ifidIr_q    <= NOP;
         ifidPc_q    <= 32'h0;
         ifidValid_q <= 1'b0;
         drainCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ifidIr_q    <= ifidIr_d;
         ifidPc_q    <= ifidPc_d;
         ifidValid_q <= ifidValid_d;
         drainCnt_q  <= drainCnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifidIr_d    = ifidIr_q;
      ifidPc_d    = ifidPc_q;
      ifidValid_d = ifidValid_q;
      drainCnt_d  = drainCnt_q;
      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               pc_d        = redirectTarget;
               ifidIr_d    = NOP;
               ifidValid_d = 1'b0;
            end else if (!stall) begin
               if (endOfProgram) begin
                  state_d     = DRAIN;
                  ifidIr_d    = NOP;
                  ifidValid_d = 1'b0;
                  drainCnt_d  = CNT_W'(DRAIN_CYCLES - 1);
               end else begin
                  ifidIr_d    = imem_rdata;
                  ifidPc_d    = pc_q;
                  ifidValid_d = 1'b1;
                  pc_d        = pc_q + 32'd4;
               end
            end
         end
         // The zero word may have been fetched down a wrong path, so a late redirect revives fetch
         DRAIN: begin
            ifidIr_d    = NOP;
            ifidValid_d = 1'b0;
            if (redirect_valid) begin
               state_d = RUN;
               pc_d    = redirectTarget;
            end else if (!stall) begin
               if (drainCnt_q == '0) begin
                  state_d = HALTED;
               end else begin
                  drainCnt_d = drainCnt_q - CNT_W'(1);
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign imem_addr  = pc_q[11:2];
   assign pc         = pc_q;
   assign ifid_ir    = ifidIr_q;
   assign ifid_pc    = ifidPc_q;
   assign ifid_valid = ifidValid_q;
   assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: constant vector tables, directed
// corner sequences and a randomized run against a behavioural reference model.
module tb_riscv_fetch_stage;
   import riscv_pkg::*;

   localparam int unsigned IMEM_DEPTH   = 1024;
   localparam int unsigned DRAIN_CYCLES = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_ir;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic [31:0] pc;
   logic        halted;

   logic [31:0] imem [IMEM_DEPTH];

   int errors = 0;
   int checks = 0;

   riscv_fetch_stage #(
      .IMEM_DEPTH(IMEM_DEPTH),
      .RESET_PC(32'h0),
      .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .ifid_ir(ifid_ir),
      .ifid_pc(ifid_pc),
      .ifid_valid(ifid_valid),
      .pc(pc),
      .halted(halted)
   );

   assign imem_rdata = imem[imem_addr];

   always #5 clk = ~clk;

   // Behavioural model: drainLeft counts the unstalled edges still owed before halting
   logic [31:0] mPc, mIr, mIrPc;
   bit          mValid, mHalted;
   int          mDrainLeft;

   task automatic modelReset();
      mPc = 32'h0; mIr = NOP; mIrPc = 32'h0; mValid = 0; mHalted = 0; mDrainLeft = 0;
   endtask

   task automatic modelEdge(input bit st, input bit rv, input logic [31:0] rpc);
      logic [31:0] word;
      bit          beyond;
      if (mHalted) return;
      if (rv) begin
         mPc = rpc & ~32'h3; mIr = NOP; mValid = 0; mDrainLeft = 0;
         return;
      end
      if (st) return;
      if (mDrainLeft > 0) begin
         mDrainLeft = mDrainLeft - 1;
         if (mDrainLeft == 0) mHalted = 1;
         return;
      end
      beyond = (mPc / 4) >= IMEM_DEPTH;
      word   = imem[(mPc / 4) % IMEM_DEPTH];
      if (beyond || word == 32'h0) begin
         mIr = NOP; mValid = 0; mDrainLeft = DRAIN_CYCLES;
      end else begin
         mIr = word; mIrPc = mPc; mValid = 1; mPc = mPc + 32'd4;
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      check32({tag, " pc"}, pc, mPc);
      check32({tag, " imem_addr"}, {22'h0, imem_addr}, (mPc / 4) % 1024);
      check32({tag, " ifid_ir"}, ifid_ir, mIr);
      check32({tag, " ifid_valid"}, {31'h0, ifid_valid}, {31'h0, mValid});
      check32({tag, " halted"}, {31'h0, halted}, {31'h0, mHalted});
      if (mValid) check32({tag, " ifid_pc"}, ifid_pc, mIrPc);
   endtask

   task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc);
      stall = st; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk);
      modelEdge(st, rv, rpc);
      #1;
   endtask

   // Reset is raised mid-cycle so the outputs are checked before any clock edge
   task automatic doAsyncReset(input string tag);
      @(negedge clk);
      #2;
      stall = 0; redirect_valid = 0; redirect_pc = 32'h0;
      reset = 1'b1;
      modelReset();
      #1;
      check32({tag, " reset pc"}, pc, 32'h0);
      check32({tag, " reset ifid_ir"}, ifid_ir, NOP);
      check32({tag, " reset ifid_pc"}, ifid_pc, 32'h0);
      check32({tag, " reset ifid_valid"}, {31'h0, ifid_valid}, 32'h0);
      check32({tag, " reset halted"}, {31'h0, halted}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fillDefault();
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0000_0013 | (32'(i + 1) << 20);
   endtask

   typedef struct {
      bit          st;
      bit          rv;
      logic [31:0] rpc;
      logic [31:0] eIr;
      logic [31:0] eIrPc;
      bit          eValid;
      logic [31:0] ePc;
      bit          eHalt;
   } vec_t;

   vec_t vecs [17];

   task automatic runVectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rpc);
         check32($sformatf("vec%0d ifid_ir", i), ifid_ir, vecs[i].eIr);
         check32($sformatf("vec%0d ifid_pc", i), ifid_pc, vecs[i].eIrPc);
         check32($sformatf("vec%0d ifid_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].eValid});
         check32($sformatf("vec%0d pc", i), pc, vecs[i].ePc);
         check32($sformatf("vec%0d halted", i), {31'h0, halted}, {31'h0, vecs[i].eHalt});
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0]  = '{0, 0, 32'h0,  32'h00500093, 32'h0,  1, 32'h4,  0};
      vecs[1]  = '{0, 0, 32'h0,  32'h00A00113, 32'h4,  1, 32'h8,  0};
      vecs[2]  = '{0, 0, 32'h0,  32'h002081B3, 32'h8,  1, 32'hC,  0};
      vecs[3]  = '{0, 0, 32'h0,  NOP,          32'h8,  0, 32'hC,  0};
      vecs[4]  = '{0, 0, 32'h0,  NOP,          32'h8,  0, 32'hC,  0};
      vecs[5]  = '{0, 0, 32'h0,  NOP,          32'h8,  0, 32'hC,  0};
      vecs[6]  = '{0, 0, 32'h0,  NOP,          32'h8,  0, 32'hC,  0};
      vecs[7]  = '{0, 0, 32'h0,  NOP,          32'h8,  0, 32'hC,  1};
      vecs[8]  = '{1, 1, 32'h40, NOP,          32'h8,  0, 32'hC,  1};
      vecs[9]  = '{0, 0, 32'h0,  32'h00500093, 32'h0,  1, 32'h4,  0};
      vecs[10] = '{0, 0, 32'h0,  32'h00A00113, 32'h4,  1, 32'h8,  0};
      vecs[11] = '{0, 0, 32'h0,  32'h002081B3, 32'h8,  1, 32'hC,  0};
      vecs[12] = '{1, 0, 32'h0,  32'h002081B3, 32'h8,  1, 32'hC,  0};
      vecs[13] = '{1, 0, 32'h0,  32'h002081B3, 32'h8,  1, 32'hC,  0};
      vecs[14] = '{0, 0, 32'h0,  32'h00400213, 32'hC,  1, 32'h10, 0};
      vecs[15] = '{1, 1, 32'h23, NOP,          32'hC,  0, 32'h20, 0};
      vecs[16] = '{0, 0, 32'h0,  32'h00800293, 32'h20, 1, 32'h24, 0};

      // Free-run to end of program, then confirm halted ignores stall and redirect
      fillDefault();
      imem[0] = 32'h00500093; imem[1] = 32'h00A00113; imem[2] = 32'h002081B3; imem[3] = 32'h0;
      doAsyncReset("init");
      runVectors(0, 8);

      // Stall hold, then redirect overriding a stall
      imem[3] = 32'h00400213; imem[8] = 32'h00800293;
      doAsyncReset("stallSeq");
      runVectors(9, 16);

      // Redirect during drain after one drain edge revives fetch
      fillDefault();
      imem[4]  = 32'h0;
      imem[16] = 32'h01000093;
      doAsyncReset("drainRedir");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 32'h0);
         checkOutput("drainRedir run");
      end
      applyStimulus(0, 1, 32'h40);
      checkOutput("drainRedir edge");
      check32("drainRedir pc", pc, 32'h40);
      applyStimulus(0, 0, 32'h0);
      check32("drainRedir fetched", ifid_ir, 32'h01000093);
      check32("drainRedir halted", {31'h0, halted}, 32'h0);

      // Asynchronous reset mid-drain and again once halted
      doAsyncReset("midRun");
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'h0);
      checkOutput("preDrainReset");
      doAsyncReset("midDrain");
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 32'h0);
      check32("reachedHalt", {31'h0, halted}, 32'h1);
      doAsyncReset("inHalted");

      // Running off the end of instruction memory counts as end of program
      fillDefault();
      doAsyncReset("range");
      applyStimulus(0, 1, 32'hFF8);
      checkOutput("range redir");
      for (int i = 0; i < 3 + DRAIN_CYCLES; i++) begin
         applyStimulus(0, 0, 32'h0);
         checkOutput("range run");
      end
      check32("range pc", pc, 32'h1000);
      check32("range halted", {31'h0, halted}, 32'h1);

      // Randomized run against the reference model
      for (int i = 0; i < IMEM_DEPTH; i++)
         imem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
      doAsyncReset("random");
      for (int n = 0; n < 2500; n++) begin
         if ((mHalted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            doAsyncReset("randomReset");
         end else begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          32'($urandom_range(0, 4 * IMEM_DEPTH + 64)));
            checkOutput("random");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
